// File: rtl/otter_pkg.sv
// Shared types for the OTTER pipelined MCU: hazard FSM states, forward selects, opcodes.
package otter_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_LU_STALL = 2'b01,
        HZ_SQUASH   = 2'b10,
        HZ_MEM_WAIT = 2'b11
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_WB    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_RF    = 2'b10
    } fwd_sel_t;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_t;

    // A decode source depends on rd only if the instruction actually reads it.
    function automatic logic hz_src_match(input logic used, input logic [REG_W-1:0] rs,
                                          input logic [REG_W-1:0] rd);
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/otter_fwd_sel.sv
// Operand forward select for one EX source: EX/MEM beats WB, x0 is never forwarded.
module otter_fwd_sel
    import otter_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    output fwd_sel_t         fwd_c
);

    always_comb begin
        fwd_c = FWD_RF;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
            fwd_c = FWD_EXMEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
            fwd_c = FWD_WB;
        end
    end

endmodule

// File: rtl/otter_hazard_ctrl.sv
// Hazard controller for the 5-stage OTTER pipeline: load-use stall, redirect squash,
// dmem wait freeze and forwarding. Perf counters are built only with OTTER_HZ_PERF_EN.
module otter_hazard_ctrl
    import otter_pkg::*;
#(
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_DEPTH = 2
`ifdef OTTER_HZ_PERF_EN
    ,
    parameter int unsigned CNT_W       = 16
`endif
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [REG_W-1:0] de_rs1,
    input  logic [REG_W-1:0] de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic             redirect,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_de_we,
    output logic             de_ex_we,
    output logic             ex_mem_we,
    output logic             de_ex_bubble,
    output logic             de_squash,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`ifdef OTTER_HZ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [1:0] ST_RUN      = 2'(HZ_RUN);
    localparam logic [1:0] ST_LU_STALL = 2'(HZ_LU_STALL);
    localparam logic [1:0] ST_SQUASH   = 2'(HZ_SQUASH);
    localparam logic [1:0] ST_MEM_WAIT = 2'(HZ_MEM_WAIT);

    localparam logic [2:0] LU_RELOAD = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_DEPTH - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] ret_q, ret_d;
    logic [2:0] cnt_q, cnt_d;
    logic [1:0] eff_state;
    logic       lu;
    logic       redirect_acc;
    fwd_sel_t   fwd_a_c, fwd_b_c;

    otter_fwd_sel u_fwd_a (
        .ex_rs        (ex_rs1),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_c        (fwd_a_c)
    );

    otter_fwd_sel u_fwd_b (
        .ex_rs        (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_c        (fwd_b_c)
    );

    // A load that writes a nonzero rd read by the decode instruction forces a stall.
    assign lu = ex_memread && ex_regwrite && (ex_rd != '0) &&
                (hz_src_match(de_rs1_used, de_rs1, ex_rd) ||
                 hz_src_match(de_rs2_used, de_rs2, ex_rd));

    // MEM_WAIT behaves as the state it interrupted once memory is ready again.
    assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        cnt_d        = cnt_q;
        redirect_acc = 1'b0;
        pc_we        = 1'b1;
        if_de_we     = 1'b1;
        de_ex_we     = 1'b1;
        ex_mem_we    = 1'b1;
        de_ex_bubble = 1'b0;
        de_squash    = 1'b0;
        fwd_a        = fwd_a_c;
        fwd_b        = fwd_b_c;

        if (redirect) begin
            redirect_acc = 1'b1;
            de_squash    = 1'b1;
            de_ex_bubble = 1'b1;
            state_d      = (FL_RELOAD == 3'd0) ? ST_RUN : ST_SQUASH;
            cnt_d        = FL_RELOAD;
        end else if (eff_state == ST_SQUASH) begin
            de_squash    = 1'b1;
            de_ex_bubble = 1'b1;
            state_d      = (cnt_q <= 3'd1) ? ST_RUN : ST_SQUASH;
            cnt_d        = (cnt_q <= 3'd1) ? 3'd0 : cnt_q - 3'd1;
        end else if (eff_state == ST_LU_STALL) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_bubble = 1'b1;
            state_d      = (cnt_q <= 3'd1) ? ST_RUN : ST_LU_STALL;
            cnt_d        = (cnt_q <= 3'd1) ? 3'd0 : cnt_q - 3'd1;
        end else if (lu) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_bubble = 1'b1;
            state_d      = (LU_RELOAD == 3'd0) ? ST_RUN : ST_LU_STALL;
            cnt_d        = LU_RELOAD;
        end else begin
            state_d      = ST_RUN;
        end

        // Memory wait freezes everything and parks the interrupted state.
        if (!dmem_ready) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            redirect_acc = 1'b0;
            state_d      = ST_MEM_WAIT;
            ret_d        = eff_state;
            cnt_d        = cnt_q;
        end

        if (!RESET_N) begin
            pc_we        = 1'b0;
            if_de_we     = 1'b0;
            de_ex_we     = 1'b0;
            ex_mem_we    = 1'b0;
            de_ex_bubble = 1'b1;
            de_squash    = 1'b1;
            fwd_a        = FWD_RF;
            fwd_b        = FWD_RF;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_RUN;
            ret_q   <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef OTTER_HZ_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // Saturating event counters.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_we && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (redirect_acc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    logic unused_acc;
    assign unused_acc = redirect_acc;
`endif

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl: combinational vector table plus multi-cycle sequences.
module tb_otter_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic       de_rs1_used, de_rs2_used, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, redirect, dmem_ready;

    logic       pc_we, if_de_we, de_ex_we, ex_mem_we, de_ex_bubble, de_squash;
    logic [1:0] fwd_a, fwd_b;
    logic       pc_we1, if_de_we1, de_ex_we1, ex_mem_we1, de_ex_bubble1, de_squash1;
    logic [1:0] fwd_a1, fwd_b1;
`ifdef OTTER_HZ_PERF_EN
    logic [15:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    otter_hazard_ctrl #(.LOAD_LAT(3), .FLUSH_DEPTH(2)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .redirect(redirect), .dmem_ready(dmem_ready),
        .pc_we(pc_we), .if_de_we(if_de_we), .de_ex_we(de_ex_we), .ex_mem_we(ex_mem_we),
        .de_ex_bubble(de_ex_bubble), .de_squash(de_squash), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef OTTER_HZ_PERF_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    otter_hazard_ctrl #(.LOAD_LAT(1), .FLUSH_DEPTH(1)) u_dut1 (
        .CLK(CLK), .RESET_N(RESET_N),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .redirect(redirect), .dmem_ready(dmem_ready),
        .pc_we(pc_we1), .if_de_we(if_de_we1), .de_ex_we(de_ex_we1), .ex_mem_we(ex_mem_we1),
        .de_ex_bubble(de_ex_bubble1), .de_squash(de_squash1), .fwd_a(fwd_a1), .fwd_b(fwd_b1)
`ifdef OTTER_HZ_PERF_EN
        , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
    );

    typedef struct {
        logic [4:0] de_rs1, de_rs2;
        logic       u1, u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       ex_mr;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic       redir;
        logic       e_pc, e_ifde, e_bub, e_sq;
        logic [1:0] e_fa, e_fb;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic vec_t mk(int a, int b, int c, int d, int e, int f, int g, int h,
                                int i, int j, int k, int l, int m,
                                int n, int o, int p, int q, int r, int s);
        vec_t v;
        v.de_rs1 = 5'(a); v.de_rs2 = 5'(b); v.u1 = 1'(c); v.u2 = 1'(d);
        v.ex_rs1 = 5'(e); v.ex_rs2 = 5'(f); v.ex_rd = 5'(g); v.ex_mr = 1'(h);
        v.mem_rd = 5'(i); v.mem_rw = 1'(j); v.wb_rd = 5'(k); v.wb_rw = 1'(l);
        v.redir = 1'(m);
        v.e_pc = 1'(n); v.e_ifde = 1'(o); v.e_bub = 1'(p); v.e_sq = 1'(q);
        v.e_fa = 2'(r); v.e_fb = 2'(s);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        de_rs1 = '0; de_rs2 = '0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0;
        redirect = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic set_lu(input logic on);
        de_rs1 = 5'd5; de_rs1_used = on; ex_rd = 5'd5; ex_memread = on; ex_regwrite = on;
    endtask

    // Advance to just after the next rising edge to drive new inputs.
    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // x0..: de_rs1 de_rs2 u1 u2 | ex_rs1 ex_rs2 ex_rd mr | mem_rd rw wb_rd rw | redir | pc ifde bub sq fa fb
        vecs[0]  = mk(0, 0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 2);
        vecs[1]  = mk(5, 0, 1, 0,  0,  0, 5, 1,  0, 0, 0, 0, 0,  0, 0, 1, 0, 2, 2);
        vecs[2]  = mk(9, 9, 0, 1,  0,  0, 9, 1,  0, 0, 0, 0, 0,  0, 0, 1, 0, 2, 2);
        vecs[3]  = mk(5, 5, 0, 0,  0,  0, 5, 1,  0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 2);
        vecs[4]  = mk(0, 0, 1, 1,  0,  0, 0, 1,  0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 2);
        vecs[5]  = mk(5, 0, 1, 0,  0,  0, 5, 0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 2, 2);
        vecs[6]  = mk(5, 0, 1, 0,  0,  0, 5, 1,  0, 0, 0, 0, 1,  1, 1, 1, 1, 2, 2);
        vecs[7]  = mk(0, 0, 0, 0,  7,  3, 0, 0,  7, 1, 7, 1, 0,  1, 1, 0, 0, 1, 2);
        vecs[8]  = mk(0, 0, 0, 0,  0,  0, 0, 0,  0, 1, 0, 1, 0,  1, 1, 0, 0, 2, 2);
        vecs[9]  = mk(0, 0, 0, 0,  4,  3, 0, 0,  4, 0, 3, 1, 0,  1, 1, 0, 0, 2, 0);
        vecs[10] = mk(0, 0, 0, 0,  7,  0, 0, 0,  7, 0, 7, 1, 0,  1, 1, 0, 0, 0, 2);
        vecs[11] = mk(0, 0, 0, 0, 12, 12, 0, 0, 12, 1, 0, 0, 0,  1, 1, 0, 0, 1, 1);
        vecs[12] = mk(0, 0, 0, 0,  6,  5, 0, 0,  5, 1, 6, 1, 0,  1, 1, 0, 0, 0, 1);
        vecs[13] = mk(3, 8, 1, 1,  8,  0, 8, 1,  8, 1, 0, 0, 0,  0, 0, 1, 0, 1, 2);

        // Reset state, with a forwarding match present that must be masked.
        clr();
        RESET_N = 1'b0;
        mem_rd = 5'd7; mem_regwrite = 1'b1; ex_rs1 = 5'd7;
        #2;
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_de_ex_we", 32'(de_ex_we), 32'd0);
        chk("rst_ex_mem_we", 32'(ex_mem_we), 32'd0);
        chk("rst_bubble", 32'(de_ex_bubble), 32'd1);
        chk("rst_squash", 32'(de_squash), 32'd1);
        chk("rst_fwd_a", 32'(fwd_a), 32'd2);
        clr();
        @(negedge CLK);
        RESET_N = 1'b1;
        next_cyc();

        // Single-cycle combinational vectors; hazards are removed before the edge so state stays RUN.
        for (int i = 0; i < NV; i++) begin
            de_rs1 = vecs[i].de_rs1; de_rs2 = vecs[i].de_rs2;
            de_rs1_used = vecs[i].u1; de_rs2_used = vecs[i].u2;
            ex_rs1 = vecs[i].ex_rs1; ex_rs2 = vecs[i].ex_rs2; ex_rd = vecs[i].ex_rd;
            ex_memread = vecs[i].ex_mr; ex_regwrite = vecs[i].ex_mr;
            mem_rd = vecs[i].mem_rd; mem_regwrite = vecs[i].mem_rw;
            wb_rd = vecs[i].wb_rd; wb_regwrite = vecs[i].wb_rw;
            redirect = vecs[i].redir;
            @(negedge CLK);
            chk($sformatf("v%0d_pc_we", i), 32'(pc_we), 32'(vecs[i].e_pc));
            chk($sformatf("v%0d_if_de_we", i), 32'(if_de_we), 32'(vecs[i].e_ifde));
            chk($sformatf("v%0d_de_ex_we", i), 32'(de_ex_we), 32'd1);
            chk($sformatf("v%0d_bubble", i), 32'(de_ex_bubble), 32'(vecs[i].e_bub));
            chk($sformatf("v%0d_squash", i), 32'(de_squash), 32'(vecs[i].e_sq));
            chk($sformatf("v%0d_fwd_a", i), 32'(fwd_a), 32'(vecs[i].e_fa));
            chk($sformatf("v%0d_fwd_b", i), 32'(fwd_b), 32'(vecs[i].e_fb));
            #1;
            clr();
            next_cyc();
        end

        // Load-use: 3 stall cycles at LOAD_LAT=3, 1 at LOAD_LAT=1.
        set_lu(1'b1);
        @(negedge CLK);
        chk("lu_c0_pc", 32'(pc_we), 32'd0);
        chk("lu_c0_bub", 32'(de_ex_bubble), 32'd1);
        chk("lu1_c0_pc", 32'(pc_we1), 32'd0);
        next_cyc();
        clr();
        @(negedge CLK);
        chk("lu_c1_pc", 32'(pc_we), 32'd0);
        chk("lu_c1_ifde", 32'(if_de_we), 32'd0);
        chk("lu1_c1_pc", 32'(pc_we1), 32'd1);
        next_cyc();
        @(negedge CLK);
        chk("lu_c2_pc", 32'(pc_we), 32'd0);
        next_cyc();
        @(negedge CLK);
        chk("lu_c3_pc", 32'(pc_we), 32'd1);
        chk("lu_c3_bub", 32'(de_ex_bubble), 32'd0);
`ifdef OTTER_HZ_PERF_EN
        chk("perf_stall_a", 32'(stall_cnt), 32'd3);
        chk("perf1_stall_a", 32'(stall_cnt1), 32'd1);
`endif
        next_cyc();

        // Redirect: FLUSH_DEPTH=2 squashes two cycles, FLUSH_DEPTH=1 one.
        redirect = 1'b1;
        @(negedge CLK);
        chk("rd_c0_sq", 32'(de_squash), 32'd1);
        chk("rd_c0_pc", 32'(pc_we), 32'd1);
        chk("rd1_c0_sq", 32'(de_squash1), 32'd1);
        next_cyc();
        redirect = 1'b0;
        @(negedge CLK);
        chk("rd_c1_sq", 32'(de_squash), 32'd1);
        chk("rd_c1_pc", 32'(pc_we), 32'd1);
        chk("rd_c1_bub", 32'(de_ex_bubble), 32'd1);
        chk("rd1_c1_sq", 32'(de_squash1), 32'd0);
        next_cyc();
        @(negedge CLK);
        chk("rd_c2_sq", 32'(de_squash), 32'd0);
        next_cyc();

        // Redirect and load-use together: no stall, and lu ignored while squashing.
        redirect = 1'b1;
        set_lu(1'b1);
        @(negedge CLK);
        chk("rl_c0_pc", 32'(pc_we), 32'd1);
        chk("rl_c0_sq", 32'(de_squash), 32'd1);
        next_cyc();
        redirect = 1'b0;
        @(negedge CLK);
        chk("rl_c1_pc", 32'(pc_we), 32'd1);
        chk("rl_c1_sq", 32'(de_squash), 32'd1);
        next_cyc();
        clr();
        @(negedge CLK);
        chk("rl_c2_sq", 32'(de_squash), 32'd0);
`ifdef OTTER_HZ_PERF_EN
        chk("perf_stall_b", 32'(stall_cnt), 32'd3);
        chk("perf_flush_b", 32'(flush_cnt), 32'd2);
`endif
        next_cyc();

        // Memory wait for 3 cycles while LU_STALL holds cnt=1.
        set_lu(1'b1);
        next_cyc();
        clr();
        next_cyc();
        dmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("mw%0d_pc", k), 32'(pc_we), 32'd0);
            chk($sformatf("mw%0d_ifde", k), 32'(if_de_we), 32'd0);
            chk($sformatf("mw%0d_deex", k), 32'(de_ex_we), 32'd0);
            chk($sformatf("mw%0d_exmem", k), 32'(ex_mem_we), 32'd0);
            next_cyc();
        end
        dmem_ready = 1'b1;
        @(negedge CLK);
        chk("mw_res_pc", 32'(pc_we), 32'd0);
        chk("mw_res_deex", 32'(de_ex_we), 32'd1);
        chk("mw_res_bub", 32'(de_ex_bubble), 32'd1);
        next_cyc();
        @(negedge CLK);
        chk("mw_end_pc", 32'(pc_we), 32'd1);
`ifdef OTTER_HZ_PERF_EN
        chk("perf_stall_c", 32'(stall_cnt), 32'd9);
`endif
        next_cyc();

        // Reset asserted mid-squash takes effect immediately.
        redirect = 1'b1;
        next_cyc();
        redirect = 1'b0;
        mem_rd = 5'd9; mem_regwrite = 1'b1; ex_rs2 = 5'd9;
        RESET_N = 1'b0;
        #1;
        chk("rs_pc", 32'(pc_we), 32'd0);
        chk("rs_ifde", 32'(if_de_we), 32'd0);
        chk("rs_bub", 32'(de_ex_bubble), 32'd1);
        chk("rs_sq", 32'(de_squash), 32'd1);
        chk("rs_fwd_b", 32'(fwd_b), 32'd2);
`ifdef OTTER_HZ_PERF_EN
        chk("rs_flush", 32'(flush_cnt), 32'd0);
`endif
        next_cyc();
        clr();
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("post_pc", 32'(pc_we), 32'd1);
        chk("post_ifde", 32'(if_de_we), 32'd1);
        chk("post_exmem", 32'(ex_mem_we), 32'd1);
        chk("post_sq", 32'(de_squash), 32'd0);
        next_cyc();
        @(negedge CLK);
        chk("post2_sq", 32'(de_squash), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
